// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one ROM read at a time and buffers the
// returned {address, instruction} pairs in a FIFO presented to decode.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       pc_i,
    input  logic                    pc_valid_i,
    output logic                    pc_ready_o,
    input  logic                    flush_i,
    output logic                    rom_ce_o,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic                    rom_rvalid_i,
    input  logic [DATA_W-1:0]       rom_rdata_i,
    output logic [DATA_W-1:0]       inst_o,
    output logic [ADDR_W-1:0]       inst_addr_o,
    output logic                    inst_valid_o,
    input  logic                    inst_ready_i,
    output logic [$clog2(DEPTH):0]  fifo_count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // WAIT keeps the response, DROP discards it after a flush.
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              push;
    logic              pop;

    // Only one request is ever outstanding, so space is checked before issue.
    assign pc_ready_o   = !rst_i && (state_q == IDLE) && !flush_i
                          && (count_q < CNT_W'(DEPTH));
    assign push         = (state_q == WAIT) && rom_rvalid_i && !flush_i;
    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = inst_valid_o ? mem_data[rd_ptr_q] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? mem_addr[rd_ptr_q] : '0;
    assign fifo_count_o = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rom_ce_o   <= 1'b0;
            rom_addr_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_valid_i && pc_ready_o) begin
                        rom_addr_o <= pc_i;
                        rom_ce_o   <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (rom_rvalid_i) begin
                        rom_ce_o <= 1'b0;
                        state_q  <= IDLE;
                    end else if (flush_i) begin
                        state_q  <= DROP;
                    end
                end
                DROP: begin
                    if (rom_rvalid_i) begin
                        rom_ce_o <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    rom_ce_o <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Flush wins over push and pop; the count moves by push minus pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; an empty FIFO never exposes its contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= rom_addr_o;
            mem_data[wr_ptr_q] <= rom_rdata_i;
        end
    end

endmodule
